// File: rtl/tcp_tx_msg_req_poller_pkg.sv
// Shared TX tile types for the message-request poller: queue entry, FSM
// states and the TX buffer free-space helper.
package tcp_tx_msg_req_poller_pkg;

    localparam int POLLER_FLOWID_W = 8;
    localparam int POLLER_PTR_W    = 8;
    localparam int POLLER_META_W   = 32;

    typedef struct packed {
        logic [POLLER_FLOWID_W-1:0] flowid;
        logic [POLLER_PTR_W:0]      len;
        logic [POLLER_META_W-1:0]   meta;
    } tcp_tx_poller_req_struct;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_RESP,
        ST_DECIDE,
        ST_SEND_RESP,
        ST_REQUEUE,
        ST_BACKOFF
    } poller_state_e;

    // Free bytes in a flow's TX buffer. Pointers carry a wrap bit, so the
    // modulo subtraction yields occupancy in 0..2^PTR_W for sane pointers.
    function automatic logic [POLLER_PTR_W+1:0] tx_free_space(
        input logic [POLLER_PTR_W:0] tail,
        input logic [POLLER_PTR_W:0] ack
    );
        logic [POLLER_PTR_W+1:0] used;
        logic [POLLER_PTR_W+1:0] buf_bytes;
        buf_bytes = {2'b01, {POLLER_PTR_W{1'b0}}};
        used      = {1'b0, tail - ack};
        return buf_bytes - used;
    endfunction

endpackage

// File: rtl/tcp_tx_poller_req_fifo.sv
// Registered 1-write/1-read FIFO of pending poller requests.
module tcp_tx_poller_req_fifo
    import tcp_tx_msg_req_poller_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  tcp_tx_poller_req_struct wr_data,
    input  logic                    rd_en,
    output tcp_tx_poller_req_struct rd_data,
    output logic                    full,
    output logic                    empty,
    output logic [CNT_W-1:0]        count
);
    localparam int AW = $clog2(DEPTH);

    tcp_tx_poller_req_struct mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    // Pointer bookkeeping; the extra MSB tells full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Storage needs no reset; occupancy is defined by the pointers alone.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    assign rd_data = mem[rd_ptr[AW-1:0]];
    assign count   = CNT_W'(wr_ptr - rd_ptr);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/tcp_tx_msg_req_poller.sv
// TX message-request poller: queues app requests, polls the flow's TX
// buffer pointers until the request fits, and answers with the write
// address. Unsatisfied requests rotate to the back of the queue.
module tcp_tx_msg_req_poller
    import tcp_tx_msg_req_poller_pkg::*;
#(
    parameter int FLOWID_W       = POLLER_FLOWID_W,
    parameter int PTR_W          = POLLER_PTR_W,
    parameter int META_W         = POLLER_META_W,
    parameter int Q_DEPTH        = 8,
    parameter int BACKOFF_CYCLES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                noc_if_poller_msg_req_val,
    input  logic [FLOWID_W-1:0] noc_if_poller_msg_req_flowid,
    input  logic [PTR_W:0]      noc_if_poller_msg_req_len,
    input  logic [META_W-1:0]   noc_if_poller_msg_req_meta,
    output logic                poller_noc_if_msg_req_rdy,
    output logic                poller_ptr_rd_req_val,
    output logic [FLOWID_W-1:0] poller_ptr_rd_req_flowid,
    input  logic                ptr_poller_rd_req_rdy,
    input  logic                ptr_poller_rd_resp_val,
    input  logic [PTR_W:0]      ptr_poller_rd_resp_tail_ptr,
    input  logic [PTR_W:0]      ptr_poller_rd_resp_ack_ptr,
    output logic                poller_ptr_rd_resp_rdy,
    output logic                poller_noc_if_msg_resp_val,
    output logic [FLOWID_W-1:0] poller_noc_if_msg_resp_flowid,
    output logic [PTR_W-1:0]    poller_noc_if_msg_resp_addr,
    output logic [PTR_W:0]      poller_noc_if_msg_resp_len,
    output logic [META_W-1:0]   poller_noc_if_msg_resp_meta,
    output logic                poller_noc_if_msg_resp_err,
    input  logic                noc_if_poller_msg_resp_rdy
);
    localparam int CNT_W = $clog2(Q_DEPTH) + 1;
    localparam int BO_W  = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;

    poller_state_e           state;
    tcp_tx_poller_req_struct head;
    tcp_tx_poller_req_struct q_wr_data;
    tcp_tx_poller_req_struct q_rd_data;
    logic                    q_wr_en, q_rd_en, q_full, q_empty;
    logic [CNT_W-1:0]        q_count;
    logic [PTR_W:0]          tail_q, ack_q;
    logic [BO_W-1:0]         bo_cnt;
    logic                    head_held, slots_full, in_push, too_big;

    // While the head is out of the queue it may come back, so its slot stays
    // reserved; that is what keeps the requeue push from ever overflowing.
    assign head_held  = (state == ST_RD_REQ) || (state == ST_RD_RESP) || (state == ST_DECIDE);
    assign slots_full = q_full || (head_held && q_count == CNT_W'(Q_DEPTH - 1));
    assign poller_noc_if_msg_req_rdy = !rst && !slots_full && (state != ST_REQUEUE);

    assign in_push   = noc_if_poller_msg_req_val && poller_noc_if_msg_req_rdy;
    assign q_wr_en   = in_push || (state == ST_REQUEUE);
    assign q_wr_data = (state == ST_REQUEUE) ? head :
                       '{flowid: noc_if_poller_msg_req_flowid,
                         len:    noc_if_poller_msg_req_len,
                         meta:   noc_if_poller_msg_req_meta};
    assign q_rd_en   = (state == ST_IDLE) && !q_empty;

    // Lengths above the buffer size can never fit.
    assign too_big = q_rd_data.len[PTR_W] && (|q_rd_data.len[PTR_W-1:0]);

    tcp_tx_poller_req_fifo #(.DEPTH(Q_DEPTH), .CNT_W(CNT_W)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (q_wr_en),
        .wr_data (q_wr_data),
        .rd_en   (q_rd_en),
        .rd_data (q_rd_data),
        .full    (q_full),
        .empty   (q_empty),
        .count   (q_count)
    );

    assign poller_ptr_rd_req_flowid = head.flowid;

    // Poll FSM with registered handshake outputs and response fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state                         <= ST_IDLE;
            head                          <= '0;
            tail_q                        <= '0;
            ack_q                         <= '0;
            bo_cnt                        <= '0;
            poller_ptr_rd_req_val         <= 1'b0;
            poller_ptr_rd_resp_rdy        <= 1'b0;
            poller_noc_if_msg_resp_val    <= 1'b0;
            poller_noc_if_msg_resp_flowid <= '0;
            poller_noc_if_msg_resp_addr   <= '0;
            poller_noc_if_msg_resp_len    <= '0;
            poller_noc_if_msg_resp_meta   <= '0;
            poller_noc_if_msg_resp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (!q_empty) begin
                    head <= q_rd_data;
                    if (too_big) begin
                        poller_noc_if_msg_resp_val    <= 1'b1;
                        poller_noc_if_msg_resp_flowid <= q_rd_data.flowid;
                        poller_noc_if_msg_resp_addr   <= '0;
                        poller_noc_if_msg_resp_len    <= q_rd_data.len;
                        poller_noc_if_msg_resp_meta   <= q_rd_data.meta;
                        poller_noc_if_msg_resp_err    <= 1'b1;
                        state                         <= ST_SEND_RESP;
                    end else begin
                        poller_ptr_rd_req_val <= 1'b1;
                        state                 <= ST_RD_REQ;
                    end
                end
                ST_RD_REQ: if (ptr_poller_rd_req_rdy) begin
                    poller_ptr_rd_req_val  <= 1'b0;
                    poller_ptr_rd_resp_rdy <= 1'b1;
                    state                  <= ST_RD_RESP;
                end
                ST_RD_RESP: if (ptr_poller_rd_resp_val) begin
                    poller_ptr_rd_resp_rdy <= 1'b0;
                    tail_q                 <= ptr_poller_rd_resp_tail_ptr;
                    ack_q                  <= ptr_poller_rd_resp_ack_ptr;
                    state                  <= ST_DECIDE;
                end
                ST_DECIDE: begin
                    if ({1'b0, head.len} <= tx_free_space(tail_q, ack_q)) begin
                        poller_noc_if_msg_resp_val    <= 1'b1;
                        poller_noc_if_msg_resp_flowid <= head.flowid;
                        poller_noc_if_msg_resp_addr   <= tail_q[PTR_W-1:0];
                        poller_noc_if_msg_resp_len    <= head.len;
                        poller_noc_if_msg_resp_meta   <= head.meta;
                        poller_noc_if_msg_resp_err    <= 1'b0;
                        state                         <= ST_SEND_RESP;
                    end else begin
                        state <= ST_REQUEUE;
                    end
                end
                ST_SEND_RESP: if (noc_if_poller_msg_resp_rdy) begin
                    poller_noc_if_msg_resp_val <= 1'b0;
                    state                      <= ST_IDLE;
                end
                ST_REQUEUE: begin
                    if (BACKOFF_CYCLES > 0) begin
                        bo_cnt <= BO_W'(BACKOFF_CYCLES - 1);
                        state  <= ST_BACKOFF;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_BACKOFF: begin
                    if (bo_cnt == '0) state <= ST_IDLE;
                    else              bo_cnt <= bo_cnt - BO_W'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
